// File: rtl/id_ex_stage_reg_if.sv
// ID->EX pipeline bus: decoded fields from the decode stage plus stall/flush
// controls, and the registered fields presented to the execution stage.
interface id_ex_stage_reg_if #(
  parameter int unsigned WORD  = 32,
  parameter int unsigned CNT_W = 16
);
  logic             freeze;
  logic             flush;
  logic             hazard;

  logic [WORD-1:0]  PC_in;
  logic [WORD-1:0]  Val_Rn_in;
  logic [WORD-1:0]  Val_Rm_in;
  logic [11:0]      Shift_operand_in;
  logic             imm_in;
  logic [23:0]      Signed_imm_24_in;
  logic [3:0]       Dest_in;
  logic [3:0]       src1_in;
  logic [3:0]       src2_in;
  logic [3:0]       EXE_CMD_in;
  logic             MEM_R_EN_in;
  logic             MEM_W_EN_in;
  logic             WB_EN_in;
  logic             B_in;
  logic             S_in;
  logic [3:0]       SR_in;

  logic [WORD-1:0]  PC;
  logic [WORD-1:0]  Val_Rn;
  logic [WORD-1:0]  Val_Rm;
  logic [11:0]      Shift_operand;
  logic             imm;
  logic [23:0]      Signed_imm_24;
  logic [3:0]       Dest;
  logic [3:0]       src1;
  logic [3:0]       src2;
  logic [3:0]       EXE_CMD;
  logic             MEM_R_EN;
  logic             MEM_W_EN;
  logic             WB_EN;
  logic             B;
  logic             S;
  logic [3:0]       SR;
  logic             is_mem;
  logic             valid;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output freeze, flush, hazard,
    output PC_in, Val_Rn_in, Val_Rm_in, Shift_operand_in, imm_in,
    output Signed_imm_24_in, Dest_in, src1_in, src2_in, EXE_CMD_in,
    output MEM_R_EN_in, MEM_W_EN_in, WB_EN_in, B_in, S_in, SR_in,
    input  PC, Val_Rn, Val_Rm, Shift_operand, imm, Signed_imm_24, Dest,
    input  src1, src2, EXE_CMD, MEM_R_EN, MEM_W_EN, WB_EN, B, S, SR,
    input  is_mem, valid, bubble_cnt
  );

  modport slave (
    input  freeze, flush, hazard,
    input  PC_in, Val_Rn_in, Val_Rm_in, Shift_operand_in, imm_in,
    input  Signed_imm_24_in, Dest_in, src1_in, src2_in, EXE_CMD_in,
    input  MEM_R_EN_in, MEM_W_EN_in, WB_EN_in, B_in, S_in, SR_in,
    output PC, Val_Rn, Val_Rm, Shift_operand, imm, Signed_imm_24, Dest,
    output src1, src2, EXE_CMD, MEM_R_EN, MEM_W_EN, WB_EN, B, S, SR,
    output is_mem, valid, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with freeze (memory stall), bubble insertion on
// flush/hazard, slot-valid tracking and a saturating bubble counter.
module id_ex_stage_reg #(
  parameter int unsigned WORD  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  id_ex_stage_reg_if.slave   bus
);

  logic [WORD-1:0]  r_pc;
  logic [WORD-1:0]  r_val_rn;
  logic [WORD-1:0]  r_val_rm;
  logic [11:0]      r_shift_operand;
  logic             r_imm;
  logic [23:0]      r_signed_imm_24;
  logic [3:0]       r_dest;
  logic [3:0]       r_src1;
  logic [3:0]       r_src2;
  logic [3:0]       r_exe_cmd;
  logic             r_mem_r_en;
  logic             r_mem_w_en;
  logic             r_wb_en;
  logic             r_b;
  logic             r_s;
  logic [3:0]       r_sr;
  logic             r_is_mem;
  logic             r_valid;
  logic [CNT_W-1:0] r_bubble_cnt;

  logic             w_bubble;
  logic             w_cnt_sat;

  // A simultaneous flush and hazard is a single bubble.
  assign w_bubble  = bus.flush | bus.hazard;
  assign w_cnt_sat = (r_bubble_cnt == '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc            <= '0;
      r_val_rn        <= '0;
      r_val_rm        <= '0;
      r_shift_operand <= '0;
      r_imm           <= 1'b0;
      r_signed_imm_24 <= '0;
      r_dest          <= '0;
      r_src1          <= '0;
      r_src2          <= '0;
      r_exe_cmd       <= '0;
      r_mem_r_en      <= 1'b0;
      r_mem_w_en      <= 1'b0;
      r_wb_en         <= 1'b0;
      r_b             <= 1'b0;
      r_s             <= 1'b0;
      r_sr            <= '0;
      r_is_mem        <= 1'b0;
      r_valid         <= 1'b0;
      r_bubble_cnt    <= '0;
    end else if (!bus.freeze) begin
      // Data fields load even for a bubble so its contents stay deterministic.
      r_pc            <= bus.PC_in;
      r_val_rn        <= bus.Val_Rn_in;
      r_val_rm        <= bus.Val_Rm_in;
      r_shift_operand <= bus.Shift_operand_in;
      r_imm           <= bus.imm_in;
      r_signed_imm_24 <= bus.Signed_imm_24_in;
      r_dest          <= bus.Dest_in;
      r_src1          <= bus.src1_in;
      r_src2          <= bus.src2_in;
      r_sr            <= bus.SR_in;
      if (w_bubble) begin
        r_exe_cmd  <= '0;
        r_mem_r_en <= 1'b0;
        r_mem_w_en <= 1'b0;
        r_wb_en    <= 1'b0;
        r_b        <= 1'b0;
        r_s        <= 1'b0;
        r_is_mem   <= 1'b0;
        r_valid    <= 1'b0;
        if (!w_cnt_sat) begin
          r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
      end else begin
        r_exe_cmd  <= bus.EXE_CMD_in;
        r_mem_r_en <= bus.MEM_R_EN_in;
        r_mem_w_en <= bus.MEM_W_EN_in;
        r_wb_en    <= bus.WB_EN_in;
        r_b        <= bus.B_in;
        r_s        <= bus.S_in;
        r_is_mem   <= bus.MEM_R_EN_in | bus.MEM_W_EN_in;
        r_valid    <= 1'b1;
      end
    end
  end

  assign bus.PC            = r_pc;
  assign bus.Val_Rn        = r_val_rn;
  assign bus.Val_Rm        = r_val_rm;
  assign bus.Shift_operand = r_shift_operand;
  assign bus.imm           = r_imm;
  assign bus.Signed_imm_24 = r_signed_imm_24;
  assign bus.Dest          = r_dest;
  assign bus.src1          = r_src1;
  assign bus.src2          = r_src2;
  assign bus.EXE_CMD       = r_exe_cmd;
  assign bus.MEM_R_EN      = r_mem_r_en;
  assign bus.MEM_W_EN      = r_mem_w_en;
  assign bus.WB_EN         = r_wb_en;
  assign bus.B             = r_b;
  assign bus.S             = r_s;
  assign bus.SR            = r_sr;
  assign bus.is_mem        = r_is_mem;
  assign bus.valid         = r_valid;
  assign bus.bubble_cnt    = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed plus randomized bench for id_ex_stage_reg against a slot-level model.
module tb_id_ex_stage_reg;
  localparam int unsigned WORD  = 32;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg_if #(.WORD(WORD), .CNT_W(CNT_W)) bus ();

  id_ex_stage_reg #(.WORD(WORD), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Expected contents of the EX slot, as a record of fields.
  typedef struct {
    logic [31:0] pc, rn, rm;
    logic [11:0] sh;
    logic        imm;
    logic [23:0] off;
    logic [3:0]  dest, s1, s2, cmd, sr;
    logic        rd, wr, wb, b, s, is_mem, valid;
    int          cnt;
  } slot_t;

  slot_t e;

  function automatic slot_t empty_slot();
    slot_t z;
    z = '{pc:0, rn:0, rm:0, sh:0, imm:0, off:0, dest:0, s1:0, s2:0, cmd:0,
          sr:0, rd:0, wr:0, wb:0, b:0, s:0, is_mem:0, valid:0, cnt:0};
    return z;
  endfunction

  // Slot behaviour at one clock edge, from the observed inputs.
  task automatic model_edge();
    slot_t n;
    if (rst) begin
      e = empty_slot();
      return;
    end
    if (bus.freeze) return;
    n = e;
    n.pc = bus.PC_in; n.rn = bus.Val_Rn_in; n.rm = bus.Val_Rm_in;
    n.sh = bus.Shift_operand_in; n.imm = bus.imm_in; n.off = bus.Signed_imm_24_in;
    n.dest = bus.Dest_in; n.s1 = bus.src1_in; n.s2 = bus.src2_in; n.sr = bus.SR_in;
    if (bus.flush || bus.hazard) begin
      n.cmd = 0; n.rd = 0; n.wr = 0; n.wb = 0; n.b = 0; n.s = 0;
      n.is_mem = 0; n.valid = 0;
      n.cnt = (e.cnt < int'(CMAX)) ? e.cnt + 1 : e.cnt;
    end else begin
      n.cmd = bus.EXE_CMD_in; n.rd = bus.MEM_R_EN_in; n.wr = bus.MEM_W_EN_in;
      n.wb = bus.WB_EN_in; n.b = bus.B_in; n.s = bus.S_in;
      n.is_mem = bus.MEM_R_EN_in || bus.MEM_W_EN_in;
      n.valid = 1'b1;
    end
    e = n;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("PC", bus.PC, e.pc);
    chk("Val_Rn", bus.Val_Rn, e.rn);
    chk("Val_Rm", bus.Val_Rm, e.rm);
    chk("Shift_operand", 32'(bus.Shift_operand), 32'(e.sh));
    chk("imm", 32'(bus.imm), 32'(e.imm));
    chk("Signed_imm_24", 32'(bus.Signed_imm_24), 32'(e.off));
    chk("Dest", 32'(bus.Dest), 32'(e.dest));
    chk("src1", 32'(bus.src1), 32'(e.s1));
    chk("src2", 32'(bus.src2), 32'(e.s2));
    chk("EXE_CMD", 32'(bus.EXE_CMD), 32'(e.cmd));
    chk("MEM_R_EN", 32'(bus.MEM_R_EN), 32'(e.rd));
    chk("MEM_W_EN", 32'(bus.MEM_W_EN), 32'(e.wr));
    chk("WB_EN", 32'(bus.WB_EN), 32'(e.wb));
    chk("B", 32'(bus.B), 32'(e.b));
    chk("S", 32'(bus.S), 32'(e.s));
    chk("SR", 32'(bus.SR), 32'(e.sr));
    chk("is_mem", 32'(bus.is_mem), 32'(e.is_mem));
    chk("valid", 32'(bus.valid), 32'(e.valid));
    chk("bubble_cnt", 32'(bus.bubble_cnt), 32'(e.cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_all_ones();
    bus.PC_in = '1; bus.Val_Rn_in = '1; bus.Val_Rm_in = '1;
    bus.Shift_operand_in = '1; bus.imm_in = 1'b1; bus.Signed_imm_24_in = '1;
    bus.Dest_in = '1; bus.src1_in = '1; bus.src2_in = '1; bus.EXE_CMD_in = '1;
    bus.MEM_R_EN_in = 1'b1; bus.MEM_W_EN_in = 1'b1; bus.WB_EN_in = 1'b1;
    bus.B_in = 1'b1; bus.S_in = 1'b1; bus.SR_in = '1;
  endtask

  task automatic rand_fields();
    bus.PC_in = $urandom; bus.Val_Rn_in = $urandom; bus.Val_Rm_in = $urandom;
    bus.Shift_operand_in = 12'($urandom); bus.imm_in = 1'($urandom);
    bus.Signed_imm_24_in = 24'($urandom); bus.Dest_in = 4'($urandom);
    bus.src1_in = 4'($urandom); bus.src2_in = 4'($urandom);
    bus.EXE_CMD_in = 4'($urandom); bus.MEM_R_EN_in = 1'($urandom);
    bus.MEM_W_EN_in = 1'($urandom); bus.WB_EN_in = 1'($urandom);
    bus.B_in = 1'($urandom); bus.S_in = 1'($urandom); bus.SR_in = 4'($urandom);
  endtask

  task automatic ctl(input logic fz, input logic fl, input logic hz);
    bus.freeze = fz; bus.flush = fl; bus.hazard = hz;
  endtask

  initial begin
    logic [11:0] shifts [4];
    shifts = '{12'h0A5, 12'h3FF, 12'h100, 12'hFFF};
    e = empty_slot();

    // Reset with every input high, held for two edges.
    set_all_ones();
    ctl(1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    ctl(1'b0, 1'b0, 1'b0);
    bus.MEM_W_EN_in = 1'b0;
    tick();
    chk("post_reset_Val_Rm", bus.Val_Rm, 32'hFFFF_FFFF);
    chk("post_reset_is_mem", 32'(bus.is_mem), 32'd1);

    // Back-to-back loads with one-edge latency.
    for (int i = 0; i < 4; i++) begin
      rand_fields();
      bus.Shift_operand_in = shifts[i];
      bus.imm_in = 1'(i % 2);
      tick();
      chk("stream_shift", 32'(bus.Shift_operand), 32'(shifts[i]));
    end

    // Freeze for 3 edges while inputs change and flush pulses.
    rand_fields();
    tick();
    for (int i = 0; i < 3; i++) begin
      rand_fields();
      ctl(1'b1, 1'(i == 1), 1'b0);
      tick();
    end
    ctl(1'b0, 1'b0, 1'b0);
    rand_fields();
    tick();

    // Flush clears controls; flush plus hazard counts once.
    rand_fields();
    bus.WB_EN_in = 1'b1; bus.MEM_W_EN_in = 1'b1; bus.B_in = 1'b1;
    ctl(1'b0, 1'b1, 1'b0);
    tick();
    chk("flush_valid", 32'(bus.valid), 32'd0);
    ctl(1'b0, 1'b1, 1'b1);
    tick();
    chk("flush_hazard_cnt", 32'(bus.bubble_cnt), 32'd2);
    ctl(1'b0, 1'b0, 1'b1);
    rand_fields();
    tick();
    ctl(1'b0, 1'b0, 1'b0);
    tick();

    // Randomized traffic with occasional stalls, bubbles and resets.
    for (int i = 0; i < 300; i++) begin
      rand_fields();
      ctl(1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 5) == 0),
          1'($urandom_range(0, 5) == 0));
      rst = 1'($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 1'b0;

    // Saturation of the bubble counter.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rand_fields();
      ctl(1'b0, 1'b1, 1'b0);
      tick();
    end
    chk("bubble_cnt_saturated", 32'(bus.bubble_cnt), CMAX);

    // Load something real, then reset with freeze and flush also asserted.
    ctl(1'b0, 1'b0, 1'b0);
    rand_fields();
    bus.MEM_R_EN_in = 1'b1;
    tick();
    ctl(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    chk("mid_reset_valid", 32'(bus.valid), 32'd0);
    chk("mid_reset_cnt", 32'(bus.bubble_cnt), 32'd0);
    rst = 1'b0;
    ctl(1'b0, 1'b0, 1'b0);
    rand_fields();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

Pipeline register between the Instruction Decode stage and the Execution stage of the five-stage ARM core. It captures every decoded field the Execution stage consumes: operand values, the 12-bit shift operand, immediate and memory flags for the Val2 generator, ALU command, write-back and memory controls, branch data and status flags. It supports a global freeze for memory stalls and a flush that inserts a bubble on a taken branch. It also tracks slot validity and counts inserted bubbles for debug.

## Interface
Parameters:
- WORD — 32 — datapath width (PC, Val_Rn, Val_Rm)
- CNT_W — 16 — width of bubble counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- freeze  in  1  hold all contents (memory stall)
- flush  in  1  replace incoming instruction with bubble (taken branch)
- hazard  in  1  decode-stage data hazard; incoming slot becomes bubble
- PC_in / PC  in/out  WORD  PC+4 of instruction
- Val_Rn_in / Val_Rn  in/out  WORD  first operand
- Val_Rm_in / Val_Rm  in/out  WORD  second register operand (to Val2 generator)
- Shift_operand_in / Shift_operand  in/out  12  shifter operand field
- imm_in / imm  in/out  1  I bit
- Signed_imm_24_in / Signed_imm_24  in/out  24  branch offset
- Dest_in / Dest  in/out  4  destination register
- src1_in / src1, src2_in / src2  in/out  4 each  source register numbers (forwarding)
- EXE_CMD_in / EXE_CMD  in/out  4  ALU command
- MEM_R_EN_in / MEM_R_EN, MEM_W_EN_in / MEM_W_EN, WB_EN_in / WB_EN, B_in / B, S_in / S  in/out  1 each  controls
- SR_in / SR  in/out  4  status flags N,Z,C,V at decode
- is_mem  out  1  registered MEM_R_EN_in | MEM_W_EN_in (to Val2 generator)
- valid  out  1  slot holds a real instruction
- bubble_cnt  out  CNT_W  saturating count of inserted bubbles

## Operation
- Per-edge priority: rst > freeze > flush > hazard > load.
- rst: every output and bubble_cnt cleared to 0; valid=0.
- freeze=1: all registers, valid and bubble_cnt hold, regardless of flush/hazard. A branch held in EX re-asserts flush after the freeze releases, so no flush is lost.
- flush=1 or hazard=1 (freeze=0): bubble. WB_EN, MEM_R_EN, MEM_W_EN, B, S, is_mem, valid are set to 0; EXE_CMD=0. Data fields (PC, Val_Rn, Val_Rm, Shift_operand, imm, Signed_imm_24, Dest, src1, src2, SR) are loaded from inputs unchanged; they are don't-care but deterministic. bubble_cnt increments by 1.
- Load (none of the above): all *_in captured; valid=1; is_mem = MEM_R_EN_in | MEM_W_EN_in.
- bubble_cnt saturates at 2^CNT_W−1 and never wraps. A flush and a hazard in the same cycle count as one bubble.
- No combinational path from any input to any output.
- MEM_R_EN and MEM_W_EN are passed through as given; the block does not check for both being set.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on outputs after edge N.
- Freeze asserted for k cycles: outputs constant for those k edges. Load resumes on the first edge with freeze=0.
- Flush at edge N: outputs after N are a bubble. The instruction presented at N is discarded; upstream is responsible for refetch.
- Reset asserted mid-stall or mid-flush: cleared on that edge. The first edge after rst deasserts behaves normally.
- Outputs are valid in the cycle after reset with all-zero values (a bubble).

## Test plan
- Reset: drive all inputs to 1s, hold rst for 2 edges -> all outputs 0, valid=0, bubble_cnt=0; on release, next edge loads Val_Rm=0xFFFFFFFF, is_mem=1 (R_EN=1).
- Load stream: 4 back-to-back instructions (e.g. Shift_operand 0x0A5, 0x3FF, 0x100, 0xFFF, imm alternating) -> each appears exactly 1 edge later, valid=1, is_mem tracks R_EN|W_EN.
- Freeze: load instr A, assert freeze 3 cycles while changing inputs and pulsing flush -> outputs stay A, bubble_cnt unchanged; release -> next input loaded.
- Flush/hazard: WB_EN_in=1, MEM_W_EN_in=1, B_in=1 with flush=1 -> WB_EN=MEM_W_EN=B=is_mem=valid=0, EXE_CMD=0, bubble_cnt+1; flush+hazard same cycle -> +1 only.
- Saturation (CNT_W=4): 20 consecutive flushes -> bubble_cnt=15 and holds at 15.
- Mid-operation reset: freeze=1 and flush=1 with rst=1 on one edge -> all cleared that edge.
